// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite types for the multi-layer interconnect: transfer types,
// response codes and the master-port state encoding.
package ahblite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // ADDR is kept in the encoding for compatibility but is never entered.
  typedef enum logic [2:0] {
    MP_IDLE = 3'd0,
    MP_PEND = 3'd1,
    MP_ADDR = 3'd2,
    MP_DATA = 3'd3,
    MP_ERR1 = 3'd4,
    MP_ERR2 = 3'd5
  } mp_state_t;

  // True when the transfer type carries a real access (NONSEQ or SEQ).
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahblite_ic_master_port_if.sv
// Master-facing AHB-Lite bus of one interconnect master port.
interface ahblite_ic_master_port_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
);
  import ahblite_pkg::*;

  // Handshake: an address phase is taken on a rising HCLK edge where
  // mst_HREADY_o is high and mst_HTRANS_i is NONSEQ/SEQ (valid); mst_HREADY_o
  // doubles as the ready of the current data phase, and the master must hold
  // its address-phase and HWDATA signals stable while mst_HREADY_o is low.
  logic [1:0]             mst_HTRANS_i;
  logic [2:0]             mst_HBURST_i;
  logic [2:0]             mst_HSIZE_i;
  logic                   mst_HWRITE_i;
  logic [HADDR_WIDTH-1:0] mst_HADDR_i;
  logic                   mst_HMASTLOCK_i;
  logic [6:0]             mst_HPROT_i;
  logic                   mst_HNONSEC_i;
  logic                   mst_HEXCL_i;
  logic [3:0]             mst_HMASTER_i;
  logic [HDATA_WIDTH-1:0] mst_HWDATA_i;
  logic [HDATA_WIDTH-1:0] mst_HRDATA_o;
  logic                   mst_HREADY_o;
  logic                   mst_HRESP_o;
  logic                   mst_HEXOKAY_o;

  modport master (
    output mst_HTRANS_i, mst_HBURST_i, mst_HSIZE_i, mst_HWRITE_i, mst_HADDR_i,
           mst_HMASTLOCK_i, mst_HPROT_i, mst_HNONSEC_i, mst_HEXCL_i,
           mst_HMASTER_i, mst_HWDATA_i,
    input  mst_HRDATA_o, mst_HREADY_o, mst_HRESP_o, mst_HEXOKAY_o
  );

  modport slave (
    input  mst_HTRANS_i, mst_HBURST_i, mst_HSIZE_i, mst_HWRITE_i, mst_HADDR_i,
           mst_HMASTLOCK_i, mst_HPROT_i, mst_HNONSEC_i, mst_HEXCL_i,
           mst_HMASTER_i, mst_HWDATA_i,
    output mst_HRDATA_o, mst_HREADY_o, mst_HRESP_o, mst_HEXOKAY_o
  );

endinterface

// File: rtl/ahblite_addr_decoder.sv
// Base/mask address decoder: one-hot select of the lowest-index matching
// window, or miss when no window matches.
module ahblite_addr_decoder
  import ahblite_pkg::*;
#(
  parameter int SLAVE       = 4,
  parameter int HADDR_WIDTH = 32
) (
  input  logic [HADDR_WIDTH-1:0]            addr_i,
  input  logic [SLAVE-1:0][HADDR_WIDTH-1:0] base_i,
  input  logic [SLAVE-1:0][HADDR_WIDTH-1:0] mask_i,
  output logic [SLAVE-1:0]                  sel_o,
  output logic                              miss_o
);

  logic [SLAVE-1:0] hit;

  // A zero mask makes the window match every address.
  always_comb begin
    hit = '0;
    for (int i = 0; i < SLAVE; i++) begin
      hit[i] = (((addr_i ^ base_i[i]) & mask_i[i]) == '0);
    end
  end

  always_comb begin
    sel_o  = '0;
    miss_o = 1'b1;
    for (int i = 0; i < SLAVE; i++) begin
      if (miss_o && hit[i]) begin
        sel_o[i] = 1'b1;
        miss_o   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahblite_ic_master_port.sv
// Master-side port of the AHB-Lite multi-layer interconnect: decodes, latches
// and forwards each transfer to one slaveport, with a built-in ERROR default slave.
module ahblite_ic_master_port
  import ahblite_pkg::*;
#(
  parameter int SLAVE       = 4,
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  ahblite_ic_master_port_if.slave           mst,

  output logic [1:0]                        slv_HTRANS_o,
  output logic [2:0]                        slv_HBURST_o,
  output logic [2:0]                        slv_HSIZE_o,
  output logic                              slv_HWRITE_o,
  output logic [HADDR_WIDTH-1:0]            slv_HADDR_o,
  output logic                              slv_HMASTLOCK_o,
  output logic [6:0]                        slv_HPROT_o,
  output logic                              slv_HNONSEC_o,
  output logic                              slv_HEXCL_o,
  output logic [3:0]                        slv_HMASTER_o,
  output logic [HDATA_WIDTH-1:0]            slv_HWDATA_o,

  output logic [SLAVE-1:0]                  slv_req_o,
  input  logic [SLAVE-1:0]                  slv_gnt_i,
  input  logic [SLAVE-1:0][HDATA_WIDTH-1:0] slv_HRDATA_i,
  input  logic [SLAVE-1:0]                  slv_HREADYOUT_i,
  input  logic [SLAVE-1:0]                  slv_HRESP_i,
  input  logic [SLAVE-1:0]                  slv_HEXOKAY_i,
  input  logic [SLAVE-1:0][HADDR_WIDTH-1:0] slv_HADDR_base_i,
  input  logic [SLAVE-1:0][HADDR_WIDTH-1:0] slv_HADDR_mask_i,

  output logic [2:0]                        dbg_state_o
);

  localparam logic [2:0] ST_IDLE = MP_IDLE;
  localparam logic [2:0] ST_PEND = MP_PEND;
  localparam logic [2:0] ST_DATA = MP_DATA;
  localparam logic [2:0] ST_ERR1 = MP_ERR1;
  localparam logic [2:0] ST_ERR2 = MP_ERR2;

  logic [2:0]             state_q, state_d;
  logic [SLAVE-1:0]       sel_q;
  logic [1:0]             htrans_q;
  logic [2:0]             hburst_q;
  logic [2:0]             hsize_q;
  logic                   hwrite_q;
  logic [HADDR_WIDTH-1:0] haddr_q;
  logic                   hmastlock_q;
  logic [6:0]             hprot_q;
  logic                   hnonsec_q;
  logic                   hexcl_q;
  logic [3:0]             hmaster_q;

  logic [SLAVE-1:0]       dec_sel;
  logic                   dec_miss;
  logic                   accept;
  logic                   gnt_hit;
  logic                   s_ready;
  logic                   s_resp;
  logic                   s_exokay;
  logic [HDATA_WIDTH-1:0] s_rdata;

  ahblite_addr_decoder #(
    .SLAVE       (SLAVE),
    .HADDR_WIDTH (HADDR_WIDTH)
  ) u_decoder (
    .addr_i (mst.mst_HADDR_i),
    .base_i (slv_HADDR_base_i),
    .mask_i (slv_HADDR_mask_i),
    .sel_o  (dec_sel),
    .miss_o (dec_miss)
  );

  assign accept  = mst.mst_HREADY_o && htrans_active(mst.mst_HTRANS_i);
  assign gnt_hit = |(slv_gnt_i & sel_q);

  // Response of the selected slaveport; sel_q is one-hot whenever it is used.
  always_comb begin
    s_ready  = 1'b1;
    s_resp   = HRESP_OKAY;
    s_exokay = 1'b0;
    s_rdata  = '0;
    for (int i = 0; i < SLAVE; i++) begin
      if (sel_q[i]) begin
        s_ready  = slv_HREADYOUT_i[i];
        s_resp   = slv_HRESP_i[i];
        s_exokay = slv_HEXOKAY_i[i];
        s_rdata  = slv_HRDATA_i[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = dec_miss ? ST_ERR1 : ST_PEND;
      ST_PEND: if (gnt_hit) state_d = ST_DATA;
      ST_DATA: begin
        if (s_ready) begin
          if (accept) state_d = dec_miss ? ST_ERR1 : ST_PEND;
          else        state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: begin
        if (accept) state_d = dec_miss ? ST_ERR1 : ST_PEND;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      htrans_q    <= HTRANS_IDLE;
      hburst_q    <= '0;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      haddr_q     <= '0;
      hmastlock_q <= 1'b0;
      hprot_q     <= '0;
      hnonsec_q   <= 1'b0;
      hexcl_q     <= 1'b0;
      hmaster_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q       <= dec_sel;
        htrans_q    <= mst.mst_HTRANS_i;
        hburst_q    <= mst.mst_HBURST_i;
        hsize_q     <= mst.mst_HSIZE_i;
        hwrite_q    <= mst.mst_HWRITE_i;
        haddr_q     <= mst.mst_HADDR_i;
        hmastlock_q <= mst.mst_HMASTLOCK_i;
        hprot_q     <= mst.mst_HPROT_i;
        hnonsec_q   <= mst.mst_HNONSEC_i;
        hexcl_q     <= mst.mst_HEXCL_i;
        hmaster_q   <= mst.mst_HMASTER_i;
      end
    end
  end

  // Master-side response: PEND and ERR1 stall the master, DATA follows the slave.
  always_comb begin
    mst.mst_HREADY_o  = 1'b1;
    mst.mst_HRESP_o   = HRESP_OKAY;
    mst.mst_HEXOKAY_o = 1'b0;
    mst.mst_HRDATA_o  = '0;
    case (state_q)
      ST_PEND: mst.mst_HREADY_o = 1'b0;
      ST_DATA: begin
        mst.mst_HREADY_o  = s_ready;
        mst.mst_HRESP_o   = s_resp;
        mst.mst_HEXOKAY_o = s_exokay;
        mst.mst_HRDATA_o  = s_rdata;
      end
      ST_ERR1: begin
        mst.mst_HREADY_o = 1'b0;
        mst.mst_HRESP_o  = HRESP_ERROR;
      end
      ST_ERR2: mst.mst_HRESP_o = HRESP_ERROR;
      default: ;
    endcase
  end

  // A locked sequence keeps its slaveport claimed through the data phase.
  assign slv_req_o = ((state_q == ST_PEND) || ((state_q == ST_DATA) && hmastlock_q))
                     ? sel_q : '0;

  assign slv_HTRANS_o    = (state_q == ST_PEND) ? htrans_q : HTRANS_IDLE;
  assign slv_HBURST_o    = hburst_q;
  assign slv_HSIZE_o     = hsize_q;
  assign slv_HWRITE_o    = hwrite_q;
  assign slv_HADDR_o     = haddr_q;
  assign slv_HMASTLOCK_o = hmastlock_q;
  assign slv_HPROT_o     = hprot_q;
  assign slv_HNONSEC_o   = hnonsec_q;
  assign slv_HEXCL_o     = hexcl_q;
  assign slv_HMASTER_o   = hmaster_q;
  assign slv_HWDATA_o    = mst.mst_HWDATA_i;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahblite_ic_master_port.sv
// Directed bench for ahblite_ic_master_port: decode, wait states, default
// slave, lock, back-to-back accept and asynchronous reset.
module tb_ahblite_ic_master_port;
  import ahblite_pkg::*;

  localparam int SLAVE = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  ahblite_ic_master_port_if #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) mst_if ();

  logic [1:0]                slv_HTRANS_o;
  logic [2:0]                slv_HBURST_o;
  logic [2:0]                slv_HSIZE_o;
  logic                      slv_HWRITE_o;
  logic [AW-1:0]             slv_HADDR_o;
  logic                      slv_HMASTLOCK_o;
  logic [6:0]                slv_HPROT_o;
  logic                      slv_HNONSEC_o;
  logic                      slv_HEXCL_o;
  logic [3:0]                slv_HMASTER_o;
  logic [DW-1:0]             slv_HWDATA_o;
  logic [SLAVE-1:0]          slv_req_o;
  logic [SLAVE-1:0]          slv_gnt_i;
  logic [SLAVE-1:0][DW-1:0]  slv_HRDATA_i;
  logic [SLAVE-1:0]          slv_HREADYOUT_i;
  logic [SLAVE-1:0]          slv_HRESP_i;
  logic [SLAVE-1:0]          slv_HEXOKAY_i;
  logic [SLAVE-1:0][AW-1:0]  slv_HADDR_base_i;
  logic [SLAVE-1:0][AW-1:0]  slv_HADDR_mask_i;
  logic [2:0]                dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  int low_cnt;

  always #5 HCLK = ~HCLK;

  ahblite_ic_master_port #(.SLAVE(SLAVE), .HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .mst              (mst_if.slave),
    .slv_HTRANS_o     (slv_HTRANS_o),
    .slv_HBURST_o     (slv_HBURST_o),
    .slv_HSIZE_o      (slv_HSIZE_o),
    .slv_HWRITE_o     (slv_HWRITE_o),
    .slv_HADDR_o      (slv_HADDR_o),
    .slv_HMASTLOCK_o  (slv_HMASTLOCK_o),
    .slv_HPROT_o      (slv_HPROT_o),
    .slv_HNONSEC_o    (slv_HNONSEC_o),
    .slv_HEXCL_o      (slv_HEXCL_o),
    .slv_HMASTER_o    (slv_HMASTER_o),
    .slv_HWDATA_o     (slv_HWDATA_o),
    .slv_req_o        (slv_req_o),
    .slv_gnt_i        (slv_gnt_i),
    .slv_HRDATA_i     (slv_HRDATA_i),
    .slv_HREADYOUT_i  (slv_HREADYOUT_i),
    .slv_HRESP_i      (slv_HRESP_i),
    .slv_HEXOKAY_i    (slv_HEXOKAY_i),
    .slv_HADDR_base_i (slv_HADDR_base_i),
    .slv_HADDR_mask_i (slv_HADDR_mask_i),
    .dbg_state_o      (dbg_state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [1:0] trans, input logic write,
                       input logic [31:0] addr, input logic lock);
    mst_if.mst_HTRANS_i    = trans;
    mst_if.mst_HWRITE_i    = write;
    mst_if.mst_HADDR_i     = addr;
    mst_if.mst_HMASTLOCK_i = lock;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_hready"},  64'(mst_if.mst_HREADY_o),  64'd1);
    chk({tag, "_hresp"},   64'(mst_if.mst_HRESP_o),   64'd0);
    chk({tag, "_hexokay"}, 64'(mst_if.mst_HEXOKAY_o), 64'd0);
    chk({tag, "_hrdata"},  64'(mst_if.mst_HRDATA_o),  64'd0);
    chk({tag, "_req"},     64'(slv_req_o),            64'd0);
    chk({tag, "_htrans"},  64'(slv_HTRANS_o),         64'd0);
    chk({tag, "_haddr"},   64'(slv_HADDR_o),          64'd0);
    chk({tag, "_hsize"},   64'(slv_HSIZE_o),          64'd0);
    chk({tag, "_hlock"},   64'(slv_HMASTLOCK_o),      64'd0);
    chk({tag, "_state"},   64'(dbg_state_o),          64'(MP_IDLE));
  endtask

  initial begin
    // Windows: 0 -> 0x0xxx_xxxx, 1 -> 0x4xxx_xxxx, 2 -> 0x2xxx_xxxx, 3 -> 0x4/0x5xxx_xxxx
    slv_HADDR_base_i[0] = 32'h0000_0000; slv_HADDR_mask_i[0] = 32'hF000_0000;
    slv_HADDR_base_i[1] = 32'h4000_0000; slv_HADDR_mask_i[1] = 32'hF000_0000;
    slv_HADDR_base_i[2] = 32'h2000_0000; slv_HADDR_mask_i[2] = 32'hF000_0000;
    slv_HADDR_base_i[3] = 32'h4000_0000; slv_HADDR_mask_i[3] = 32'hE000_0000;
    slv_gnt_i       = '0;
    slv_HRDATA_i    = '0;
    slv_HREADYOUT_i = '1;
    slv_HRESP_i     = '0;
    slv_HEXOKAY_i   = '0;
    mst_if.mst_HBURST_i  = 3'd0;
    mst_if.mst_HSIZE_i   = 3'd2;
    mst_if.mst_HPROT_i   = 7'h03;
    mst_if.mst_HNONSEC_i = 1'b0;
    mst_if.mst_HEXCL_i   = 1'b0;
    mst_if.mst_HMASTER_i = 4'h5;
    mst_if.mst_HWDATA_i  = '0;
    drive(HTRANS_NONSEQ, 1'b1, 32'h2000_0010, 1'b0);

    // Reset held with NONSEQ presented
    #12;
    chk_reset_values("rst");
    #11;
    HRESETn = 1'b1;
    #1;
    chk("post_rst_req", 64'(slv_req_o), 64'd0);
    chk("post_rst_state", 64'(dbg_state_o), 64'(MP_IDLE));

    // Write to slave 2, immediate grant, zero-wait slave
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 1'b0);
    mst_if.mst_HWDATA_i = 32'hDEAD_BEEF;
    slv_gnt_i = 4'b0100;
    slv_HRDATA_i[2] = 32'h1234_5678;
    settle();
    chk("wr_pend_state", 64'(dbg_state_o), 64'(MP_PEND));
    chk("wr_pend_req", 64'(slv_req_o), 64'b0100);
    chk("wr_pend_htrans", 64'(slv_HTRANS_o), 64'(HTRANS_NONSEQ));
    chk("wr_pend_haddr", 64'(slv_HADDR_o), 64'h2000_0010);
    chk("wr_pend_hwrite", 64'(slv_HWRITE_o), 64'd1);
    chk("wr_pend_hsize", 64'(slv_HSIZE_o), 64'd2);
    chk("wr_pend_hprot", 64'(slv_HPROT_o), 64'h03);
    chk("wr_pend_hmaster", 64'(slv_HMASTER_o), 64'h5);
    chk("wr_pend_hready", 64'(mst_if.mst_HREADY_o), 64'd0);
    chk("wr_pend_hwdata", 64'(slv_HWDATA_o), 64'hDEAD_BEEF);
    step();
    slv_gnt_i = '0;
    settle();
    chk("wr_data_state", 64'(dbg_state_o), 64'(MP_DATA));
    chk("wr_data_req", 64'(slv_req_o), 64'd0);
    chk("wr_data_htrans", 64'(slv_HTRANS_o), 64'(HTRANS_IDLE));
    chk("wr_data_hready", 64'(mst_if.mst_HREADY_o), 64'd1);
    chk("wr_data_hwdata", 64'(slv_HWDATA_o), 64'hDEAD_BEEF);
    chk("wr_data_hrdata", 64'(mst_if.mst_HRDATA_o), 64'h1234_5678);
    step();
    settle();
    chk("wr_done_state", 64'(dbg_state_o), 64'(MP_IDLE));
    chk("wr_done_hrdata", 64'(mst_if.mst_HRDATA_o), 64'd0);

    // Unmapped read: two-cycle ERROR from the default slave
    drive(HTRANS_NONSEQ, 1'b0, 32'h9000_0000, 1'b0);
    settle();
    chk("err_idle_hready", 64'(mst_if.mst_HREADY_o), 64'd1);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 1'b0);
    settle();
    chk("err1_state", 64'(dbg_state_o), 64'(MP_ERR1));
    chk("err1_hready", 64'(mst_if.mst_HREADY_o), 64'd0);
    chk("err1_hresp", 64'(mst_if.mst_HRESP_o), 64'd1);
    chk("err1_req", 64'(slv_req_o), 64'd0);
    step();
    settle();
    chk("err2_hready", 64'(mst_if.mst_HREADY_o), 64'd1);
    chk("err2_hresp", 64'(mst_if.mst_HRESP_o), 64'd1);
    chk("err2_req", 64'(slv_req_o), 64'd0);
    step();
    settle();
    chk("err_done_state", 64'(dbg_state_o), 64'(MP_IDLE));
    chk("err_done_hresp", 64'(mst_if.mst_HRESP_o), 64'd0);

    // Windows 1 and 3 both match: lowest index wins
    drive(HTRANS_NONSEQ, 1'b0, 32'h4000_0100, 1'b0);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 1'b0);
    slv_gnt_i = 4'b0010;
    slv_HRDATA_i[1] = 32'hA5A5_0001;
    slv_HEXOKAY_i[1] = 1'b1;
    settle();
    chk("ovl_req", 64'(slv_req_o), 64'b0010);
    step();
    slv_gnt_i = '0;
    settle();
    chk("ovl_data_hrdata", 64'(mst_if.mst_HRDATA_o), 64'hA5A5_0001);
    chk("ovl_data_hexokay", 64'(mst_if.mst_HEXOKAY_o), 64'd1);
    chk("ovl_data_hresp", 64'(mst_if.mst_HRESP_o), 64'd0);
    step();
    slv_HEXOKAY_i[1] = 1'b0;
    settle();
    chk("ovl_done_state", 64'(dbg_state_o), 64'(MP_IDLE));

    // Grant withheld 5 cycles, 2 slave wait states, second NONSEQ waiting
    drive(HTRANS_NONSEQ, 1'b1, 32'h2000_0020, 1'b0);
    low_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) drive(HTRANS_NONSEQ, 1'b0, 32'h0000_0040, 1'b0);
      slv_gnt_i = (c == 5) ? 4'b0100 : 4'b0000;
      settle();
      chk("gw_pend_state", 64'(dbg_state_o), 64'(MP_PEND));
      chk("gw_pend_haddr", 64'(slv_HADDR_o), 64'h2000_0020);
      chk("gw_pend_htrans", 64'(slv_HTRANS_o), 64'(HTRANS_NONSEQ));
      if (!mst_if.mst_HREADY_o) low_cnt++;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      slv_gnt_i = '0;
      slv_HREADYOUT_i[2] = (c == 2);
      settle();
      chk("gw_data_state", 64'(dbg_state_o), 64'(MP_DATA));
      if (!mst_if.mst_HREADY_o) low_cnt++;
    end
    chk("gw_last_hready", 64'(mst_if.mst_HREADY_o), 64'd1);
    chk("gw_low_cycles", 64'(low_cnt), 64'd8);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 1'b0);
    slv_HREADYOUT_i = '1;
    slv_gnt_i = 4'b0001;
    slv_HRDATA_i[0] = 32'h0BAD_F00D;
    slv_HRESP_i[0] = 1'b1;
    settle();
    chk("b2b_state", 64'(dbg_state_o), 64'(MP_PEND));
    chk("b2b_req", 64'(slv_req_o), 64'b0001);
    chk("b2b_haddr", 64'(slv_HADDR_o), 64'h0000_0040);
    chk("b2b_hwrite", 64'(slv_HWRITE_o), 64'd0);
    step();
    slv_gnt_i = '0;
    settle();
    chk("b2b_hrdata", 64'(mst_if.mst_HRDATA_o), 64'h0BAD_F00D);
    chk("b2b_hresp_fwd", 64'(mst_if.mst_HRESP_o), 64'd1);
    step();
    slv_HRESP_i = '0;
    settle();
    chk("b2b_done_state", 64'(dbg_state_o), 64'(MP_IDLE));

    // Locked two-beat sequence to slave 0
    drive(HTRANS_NONSEQ, 1'b1, 32'h0000_0100, 1'b1);
    step();
    drive(HTRANS_SEQ, 1'b1, 32'h0000_0104, 1'b1);
    slv_gnt_i = 4'b0001;
    settle();
    chk("lk_pend1_req", 64'(slv_req_o), 64'b0001);
    step();
    slv_gnt_i = '0;
    settle();
    chk("lk_data1_req", 64'(slv_req_o), 64'b0001);
    chk("lk_data1_state", 64'(dbg_state_o), 64'(MP_DATA));
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 1'b0);
    slv_gnt_i = 4'b0001;
    settle();
    chk("lk_pend2_req", 64'(slv_req_o), 64'b0001);
    chk("lk_pend2_htrans", 64'(slv_HTRANS_o), 64'(HTRANS_SEQ));
    chk("lk_pend2_haddr", 64'(slv_HADDR_o), 64'h0000_0104);
    chk("lk_pend2_hlock", 64'(slv_HMASTLOCK_o), 64'd1);
    step();
    slv_gnt_i = '0;
    settle();
    chk("lk_data2_req", 64'(slv_req_o), 64'b0001);
    step();
    settle();
    chk("lk_done_req", 64'(slv_req_o), 64'd0);

    // Reset asserted during a stalled data phase
    drive(HTRANS_NONSEQ, 1'b0, 32'h2000_0080, 1'b0);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 1'b0);
    slv_gnt_i = 4'b0100;
    step();
    slv_gnt_i = '0;
    slv_HREADYOUT_i[2] = 1'b0;
    slv_HRDATA_i[2] = 32'hCAFE_0000;
    settle();
    chk("ar_data_state", 64'(dbg_state_o), 64'(MP_DATA));
    chk("ar_data_hrdata", 64'(mst_if.mst_HRDATA_o), 64'hCAFE_0000);
    chk("ar_data_hready", 64'(mst_if.mst_HREADY_o), 64'd0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk_reset_values("arst");
    #10;
    HRESETn = 1'b1;
    slv_HREADYOUT_i = '1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahblite_ic_master_port.md
# ahblite_ic_master_port

Master-side port of the AHB-Lite multi-layer interconnect, one instance per AHB-Lite master. It decodes each accepted address phase against SLAVE base/mask windows, latches the command and requests the target slaveport. It holds the master with HREADY low until the slave completes the data phase, and answers unmapped accesses with a built-in two-cycle ERROR default slave.

## Interface
- SLAVE, 4, number of slaveports (≥1)
- HADDR_WIDTH, 32, address width
- HDATA_WIDTH, 32, data width
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous, active-low reset
- mst_HTRANS_i, mst_HBURST_i, mst_HSIZE_i, mst_HWRITE_i, mst_HADDR_i, mst_HMASTLOCK_i, mst_HPROT_i, mst_HNONSEC_i, mst_HEXCL_i, mst_HMASTER_i  in  2/3/3/1/HADDR_WIDTH/1/7/1/1/4  master address phase
- mst_HWDATA_i  in  HDATA_WIDTH  master write data
- mst_HRDATA_o  out  HDATA_WIDTH  read data to master
- mst_HREADY_o, mst_HRESP_o, mst_HEXOKAY_o  out  1 each  transfer response to master
- slv_HTRANS_o … slv_HMASTER_o  out  same widths as master inputs  registered command to all slaveports
- slv_HWDATA_o  out  HDATA_WIDTH  pass-through of mst_HWDATA_i
- slv_req_o  out  SLAVE  one-hot access request
- slv_gnt_i  in  SLAVE  same-cycle grant from slaveport arbiter
- slv_HRDATA_i  in  SLAVE×HDATA_WIDTH  per-slave read data
- slv_HREADYOUT_i, slv_HRESP_i, slv_HEXOKAY_i  in  SLAVE each  per-slave response
- slv_HADDR_base_i, slv_HADDR_mask_i  in  SLAVE×HADDR_WIDTH  decode windows

## Operation
- Hit[i] = ((mst_HADDR_i ^ base[i]) & mask[i]) == 0. Multiple hits: lowest index wins. No hit: default slave. mask 0 matches all addresses.
- A transfer is accepted on a rising edge where mst_HREADY_o=1 and mst_HTRANS_i ∈ {NONSEQ, SEQ}. The full command and the one-hot select are latched.
- IDLE/BUSY with HREADY high: zero-wait OKAY, no request.
- FSM states IDLE, PEND, ADDR, DATA, ERR1, ERR2.
- IDLE: accept hit → PEND; accept miss → ERR1.
- PEND: slv_req_o[sel]=1. When slv_gnt_i[sel]=1 the cycle is the slave address phase (slv_HTRANS_o = latched value) → DATA.
- DATA: mst_HREADY_o/HRESP/HEXOKAY/HRDATA = slave[sel]. On slv_HREADYOUT_i[sel]=1, complete. A new accept that edge → PEND/ERR1, else → IDLE.
- ERR1: HREADY=0, HRESP=1 → ERR2. ERR2: HREADY=1, HRESP=1; accepts like DATA-complete.
- Lock: while latched HMASTLOCK=1, slv_req_o[sel] also stays high in DATA.
- Slave ERROR responses are forwarded unmodified. The master's data phase covers PEND..DATA, so HWDATA is stable and passed through.

## Timing
- Reset values: mst_HREADY_o=1, mst_HRESP_o=0, mst_HEXOKAY_o=0, mst_HRDATA_o=0, slv_req_o=0, slv_HTRANS_o=IDLE, all other slv_* command outputs 0, FSM=IDLE.
- slv_HTRANS_o is IDLE outside PEND.
- mst_HRDATA_o is 0 outside DATA.
- Minimum latency: accept at edge E0, PEND+grant, DATA with HREADYOUT=1, complete at E2. This is one wait state to the master.
- Back-to-back: a new transfer is accepted on the completing edge, with no idle cycle.
- PEND with grant withheld: hold indefinitely, HREADY=0, command stable.
- ADDR is reserved (encoded, unreachable). The state register is 3 bits.
- Reset asserted mid-transfer: immediate return to reset values. The slaveport is responsible for abandoning its own data phase.

## Structure
- Shared package ahblite_pkg: htrans_t (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HRESP_OKAY/HRESP_ERROR, mp_state_t enum.
- Sub-module ahblite_addr_decoder: combinational, parametrised SLAVE/HADDR_WIDTH; outputs one-hot sel and miss.

## Test plan
- Reset with HTRANS=NONSEQ held → all outputs at reset values; no slv_req_o until the first post-reset edge.
- SLAVE=4, base[2]=0x2000_0000, mask=0xF000_0000; write to 0x2000_0010, gnt immediate, HREADYOUT=1 → slv_req_o=4'b0100 for 1 cycle; slv_HADDR_o=0x2000_0010; HWDATA passes through; master sees exactly 1 wait state.
- Read to unmapped 0x9000_0000 → HREADY/HRESP = 0/1 then 1/1; slv_req_o stays 0.
- Overlapping windows 1 and 3 both hit → slv_req_o=4'b0010.
- Grant withheld 5 cycles, then slave inserts 2 wait states; a second NONSEQ is presented → HREADY low 8 cycles; second transfer accepted on the completing edge; PEND follows directly.
- Locked two-beat sequence to slave 0 → slv_req_o[0] continuously high from first PEND through final DATA.
- HRESETn asserted during DATA → outputs return to reset values asynchronously.
